// File: rtl/data_cache_pkg.sv
// Shared constants, state encoding and request record for the direct-mapped data cache.
package data_cache_pkg;

   localparam int WORD             = 32;
   localparam int CACHE_LINE_WIDTH = 128;
   localparam int DC_LINES_DEFAULT = 64;
   localparam int BYTE_W           = 8;
   localparam int BYTE_OFF_W       = 2;
   localparam int LINE_OFF_W       = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_WB     = 3'd2,
      S_RD     = 3'd3,
      S_WAIT   = 3'd4,
      S_REFILL = 3'd5
   } state_t;

   typedef struct packed {
      logic            we;
      logic [WORD-1:0] addr;
      logic [WORD-1:0] wdata;
      logic [3:0]      wstrb;
   } dc_req_t;

endpackage

// File: rtl/data_cache_if.sv
// Pipeline request/response and memory refill/writeback signals of the data cache.
interface data_cache_if
   import data_cache_pkg::*;
#(
   parameter int LINE_WIDTH = CACHE_LINE_WIDTH
) ();

   logic                  req_valid;
   logic                  req_we;
   logic [WORD-1:0]       req_addr;
   logic [WORD-1:0]       req_wdata;
   logic [3:0]            req_wstrb;
   logic [WORD-1:0]       rdata;
   logic                  ready;
   logic                  mem_rd_req;
   logic [WORD-1:0]       mem_rd_addr;
   logic                  mem_rd_ready;
   logic                  mem_rd_valid;
   logic [LINE_WIDTH-1:0] mem_rd_data;
   logic                  mem_wr_req;
   logic [WORD-1:0]       mem_wr_addr;
   logic [LINE_WIDTH-1:0] mem_wr_data;
   logic                  mem_wr_ack;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
      input  mem_rd_ready, mem_rd_valid, mem_rd_data, mem_wr_ack,
      output rdata, ready, mem_rd_req, mem_rd_addr,
      output mem_wr_req, mem_wr_addr, mem_wr_data
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb,
      output mem_rd_ready, mem_rd_valid, mem_rd_data, mem_wr_ack,
      input  rdata, ready, mem_rd_req, mem_rd_addr,
      input  mem_wr_req, mem_wr_addr, mem_wr_data
   );

endinterface

// File: rtl/data_cache_line_ram.sv
// Cache line storage: byte-enabled synchronous write, combinational read by index.
module dcache_line_ram
   import data_cache_pkg::*;
#(
   parameter  int LINES      = DC_LINES_DEFAULT,
   parameter  int LINE_WIDTH = CACHE_LINE_WIDTH,
   localparam int IDX_W      = $clog2(LINES),
   localparam int NBYTES     = LINE_WIDTH / BYTE_W
) (
   input  logic                  clk,
   input  logic [NBYTES-1:0]     we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [LINE_WIDTH-1:0] wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [LINE_WIDTH-1:0] rdata
);

   logic [LINE_WIDTH-1:0] mem [LINES];

   // byte-lane writes into the addressed line
   always_ff @(posedge clk) begin
      for (int b = 0; b < NBYTES; b++) begin
         if (we[b]) begin
            mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back data cache with single outstanding miss and back-to-back hits.
module data_cache
   import data_cache_pkg::*;
#(
   parameter int DC_LINES   = DC_LINES_DEFAULT,
   parameter int LINE_WIDTH = CACHE_LINE_WIDTH
) (
   input logic         clk,
   input logic         rst,
   data_cache_if.slave bus
);

   localparam int IDX_W  = $clog2(DC_LINES);
   localparam int TAG_W  = WORD - LINE_OFF_W - IDX_W;
   localparam int NBYTES = LINE_WIDTH / BYTE_W;
   localparam int WORDS  = LINE_WIDTH / WORD;
   localparam int WOFF_W = $clog2(WORDS);

   state_t                state_r, state_nx;
   dc_req_t               req_r;
   logic [DC_LINES-1:0]   valid_r, dirty_r;
   logic [TAG_W-1:0]      tag_mem [DC_LINES];
   logic [LINE_WIDTH-1:0] refill_r;
   logic [WORD-1:0]       rdata_r;

   logic [IDX_W-1:0]      idx_s;
   logic [TAG_W-1:0]      tag_s;
   logic [WOFF_W-1:0]     off_s;
   logic [LINE_WIDTH-1:0] line_s, ram_wdata_s;
   logic [NBYTES-1:0]     ram_we_s;
   logic [WORD-1:0]       word_s;
   logic                  hit_s, ready_s, accept_s, store_hit_s;
   logic                  unused_addr_s;

   assign idx_s         = req_r.addr[LINE_OFF_W +: IDX_W];
   assign tag_s         = req_r.addr[WORD-1 -: TAG_W];
   assign off_s         = req_r.addr[BYTE_OFF_W +: WOFF_W];
   assign word_s        = line_s[off_s*WORD +: WORD];
   assign unused_addr_s = ^req_r.addr[BYTE_OFF_W-1:0];

   assign hit_s       = (state_r == S_LOOKUP) && valid_r[idx_s] && (tag_mem[idx_s] == tag_s);
   assign ready_s     = (state_r == S_IDLE) || hit_s;
   assign accept_s    = bus.req_valid && ready_s;
   assign store_hit_s = hit_s && req_r.we;

   // refill overwrites the whole line; a store hit writes only its strobed bytes
   always_comb begin
      ram_we_s    = '0;
      ram_wdata_s = {WORDS{req_r.wdata}};
      if (state_r == S_REFILL) begin
         ram_we_s    = '1;
         ram_wdata_s = refill_r;
      end else if (store_hit_s) begin
         ram_we_s = {{(NBYTES-4){1'b0}}, req_r.wstrb} << {off_s, 2'b00};
      end else begin
         ram_we_s = '0;
      end
   end

   dcache_line_ram #(.LINES(DC_LINES), .LINE_WIDTH(LINE_WIDTH)) u_ram (
      .clk   (clk),
      .we    (ram_we_s),
      .waddr (idx_s),
      .wdata (ram_wdata_s),
      .raddr (idx_s),
      .rdata (line_s)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // next-state logic
   always_comb begin
      state_nx = state_r;
      case (state_r)
         S_IDLE:   state_nx = bus.req_valid ? S_LOOKUP : S_IDLE;
         S_LOOKUP: begin
            if (hit_s) begin
               state_nx = bus.req_valid ? S_LOOKUP : S_IDLE;
            end else if (valid_r[idx_s] && dirty_r[idx_s]) begin
               state_nx = S_WB;
            end else begin
               state_nx = S_RD;
            end
         end
         S_WB:     state_nx = bus.mem_wr_ack   ? S_RD     : S_WB;
         S_RD:     state_nx = bus.mem_rd_ready ? S_WAIT   : S_RD;
         S_WAIT:   state_nx = bus.mem_rd_valid ? S_REFILL : S_WAIT;
         S_REFILL: state_nx = S_LOOKUP;
         default:  state_nx = S_IDLE;
      endcase
   end

   // pending request, line status bits, refill buffer and load-data hold register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_r    <= '0;
         valid_r  <= '0;
         dirty_r  <= '0;
         refill_r <= '0;
         rdata_r  <= '0;
      end else begin
         if (accept_s) begin
            req_r <= '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata, wstrb: bus.req_wstrb};
         end
         if ((state_r == S_WAIT) && bus.mem_rd_valid) begin
            refill_r <= bus.mem_rd_data;
         end
         if (state_r == S_REFILL) begin
            valid_r[idx_s] <= 1'b1;
            dirty_r[idx_s] <= 1'b0;
         end else if (store_hit_s && (req_r.wstrb != 4'b0000)) begin
            dirty_r[idx_s] <= 1'b1;
         end
         if (hit_s && !req_r.we) begin
            rdata_r <= word_s;
         end
      end
   end

   // tag array is intentionally unreset; valid bits qualify it
   always_ff @(posedge clk) begin
      if (state_r == S_REFILL) begin
         tag_mem[idx_s] <= tag_s;
      end
   end

   // outputs: memory requests decoded from state, load data bypassed on a hit
   always_comb begin
      bus.mem_rd_req  = 1'b0;
      bus.mem_rd_addr = '0;
      bus.mem_wr_req  = 1'b0;
      bus.mem_wr_addr = '0;
      bus.mem_wr_data = '0;
      case (state_r)
         S_WB: begin
            bus.mem_wr_req  = 1'b1;
            bus.mem_wr_addr = {tag_mem[idx_s], idx_s, 4'b0000};
            bus.mem_wr_data = line_s;
         end
         S_RD: begin
            bus.mem_rd_req  = 1'b1;
            bus.mem_rd_addr = {tag_s, idx_s, 4'b0000};
         end
         default: begin
            bus.mem_rd_req = 1'b0;
            bus.mem_wr_req = 1'b0;
         end
      endcase
      bus.ready = ready_s;
      bus.rdata = (hit_s && !req_r.we) ? word_s : rdata_r;
   end

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache: cold miss, hits, stores, dirty eviction, reset mid-miss.
module tb_data_cache;
   import data_cache_pkg::*;

   localparam logic [127:0] LINE_A     = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
   localparam logic [127:0] LINE_A_MOD = {32'h44444444, 32'h33333333, 32'h22222222, 32'h1111CCDD};
   localparam logic [127:0] LINE_B     = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;
   int   fails  = 0;

   data_cache_if bus ();

   data_cache dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
      bus.req_valid = v;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_wstrb = wstrb;
   endtask

   initial begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
      bus.mem_rd_ready = 1'b0;
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = '0;
      bus.mem_wr_ack   = 1'b0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {127'd0, bus.ready}, 128'd1);
      chk("rst_rdata", {96'd0, bus.rdata}, 128'd0);
      chk("rst_rd_req", {127'd0, bus.mem_rd_req}, 128'd0);
      chk("rst_wr_req", {127'd0, bus.mem_wr_req}, 128'd0);
      chk("rst_rd_addr", {96'd0, bus.mem_rd_addr}, 128'd0);
      chk("rst_wr_addr", {96'd0, bus.mem_wr_addr}, 128'd0);

      // cold load 0x40
      drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b0000);
      @(negedge clk);
      chk("cold_lookup_ready", {127'd0, bus.ready}, 128'd0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
      @(negedge clk);
      chk("cold_rd_req", {127'd0, bus.mem_rd_req}, 128'd1);
      chk("cold_rd_addr", {96'd0, bus.mem_rd_addr}, 128'h40);
      chk("cold_no_wr", {127'd0, bus.mem_wr_req}, 128'd0);
      chk("cold_rd_ready_lo", {127'd0, bus.ready}, 128'd0);
      bus.mem_rd_ready = 1'b1;
      @(negedge clk);
      bus.mem_rd_ready = 1'b0;
      chk("cold_wait_ready", {127'd0, bus.ready}, 128'd0);
      chk("cold_wait_rd_req", {127'd0, bus.mem_rd_req}, 128'd0);
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = LINE_A;
      @(negedge clk);
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = '0;
      chk("cold_refill_ready", {127'd0, bus.ready}, 128'd0);
      @(negedge clk);
      chk("cold_hit_ready", {127'd0, bus.ready}, 128'd1);
      chk("cold_hit_rdata", {96'd0, bus.rdata}, 128'h1111_1111);

      // back-to-back hit on 0x44
      drive(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'b0000);
      @(negedge clk);
      chk("hit44_ready", {127'd0, bus.ready}, 128'd1);
      chk("hit44_rdata", {96'd0, bus.rdata}, 128'h2222_2222);
      chk("hit44_no_rd", {127'd0, bus.mem_rd_req}, 128'd0);

      // partial store then reload
      drive(1'b1, 1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0011);
      @(negedge clk);
      chk("store_ready", {127'd0, bus.ready}, 128'd1);
      chk("store_rdata_hold", {96'd0, bus.rdata}, 128'h2222_2222);
      drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b0000);
      @(negedge clk);
      chk("reload_rdata", {96'd0, bus.rdata}, 128'h1111_CCDD);

      // conflicting tag forces writeback of the dirty line, ack delayed 5 cycles
      drive(1'b1, 1'b0, 32'h0000_0440, 32'h0, 4'b0000);
      @(negedge clk);
      chk("evict_lookup_ready", {127'd0, bus.ready}, 128'd0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("wb_req", {127'd0, bus.mem_wr_req}, 128'd1);
         chk("wb_addr", {96'd0, bus.mem_wr_addr}, 128'h40);
         chk("wb_data", bus.mem_wr_data, LINE_A_MOD);
         chk("wb_no_rd", {127'd0, bus.mem_rd_req}, 128'd0);
         chk("wb_ready", {127'd0, bus.ready}, 128'd0);
      end
      bus.mem_wr_ack   = 1'b1;
      bus.mem_rd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.mem_wr_ack   = 1'b0;
         bus.mem_rd_valid = 1'b0;
         chk("rd2_req", {127'd0, bus.mem_rd_req}, 128'd1);
         chk("rd2_addr", {96'd0, bus.mem_rd_addr}, 128'h440);
         chk("rd2_no_wr", {127'd0, bus.mem_wr_req}, 128'd0);
         chk("rd2_ready", {127'd0, bus.ready}, 128'd0);
      end
      bus.mem_rd_ready = 1'b1;
      @(negedge clk);
      bus.mem_rd_ready = 1'b0;
      chk("wait2_ready", {127'd0, bus.ready}, 128'd0);

      // reset while waiting for refill data
      rst = 1'b1;
      #1;
      chk("midrst_ready", {127'd0, bus.ready}, 128'd1);
      chk("midrst_rdata", {96'd0, bus.rdata}, 128'd0);
      chk("midrst_rd_req", {127'd0, bus.mem_rd_req}, 128'd0);
      chk("midrst_wr_req", {127'd0, bus.mem_wr_req}, 128'd0);
      chk("midrst_rd_addr", {96'd0, bus.mem_rd_addr}, 128'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b0000);
      @(negedge clk);
      chk("post_rst_miss", {127'd0, bus.ready}, 128'd0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
      @(negedge clk);
      chk("post_rst_no_wb", {127'd0, bus.mem_wr_req}, 128'd0);
      chk("post_rst_rd_req", {127'd0, bus.mem_rd_req}, 128'd1);
      chk("post_rst_rd_addr", {96'd0, bus.mem_rd_addr}, 128'h40);
      bus.mem_rd_ready = 1'b1;
      @(negedge clk);
      bus.mem_rd_ready = 1'b0;
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = LINE_B;
      @(negedge clk);
      bus.mem_rd_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_hit_rdata", {96'd0, bus.rdata}, 128'hA0A0_A0A0);

      // zero-strobe store must leave data and dirty state untouched
      drive(1'b1, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'b0000);
      @(negedge clk);
      chk("zstrb_ready", {127'd0, bus.ready}, 128'd1);
      drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b0000);
      @(negedge clk);
      chk("zstrb_rdata", {96'd0, bus.rdata}, 128'hA0A0_A0A0);
      drive(1'b1, 1'b0, 32'h0000_0440, 32'h0, 4'b0000);
      @(negedge clk);
      chk("zstrb_evict_miss", {127'd0, bus.ready}, 128'd0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000);
      @(negedge clk);
      chk("zstrb_clean_no_wb", {127'd0, bus.mem_wr_req}, 128'd0);
      chk("zstrb_clean_rd", {127'd0, bus.mem_rd_req}, 128'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
